async_start_scheduler: RTL and testbench

- Shares one `async` unit (ports start, clk, out) among N_REQ requesters.
- Each requester raises an asynchronous request pulse. The block synchronises and edge-detects it, then queues it as a sticky pending bit.
- Pending requests are granted round-robin. For each grant the block drives the unit's start for START_LEN cycles, then waits for a rising edge on the unit's out or a timeout, then enforces a gap before the next grant.

---
 rtl/async_sched_pkg.sv | 19 +
 rtl/start_sync_edge.sv | 25 ++
 rtl/async_start_scheduler.sv | 125 ++++++++++++
 tb/tb_async_start_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/async_sched_pkg.sv
// async_sched_pkg: shared state encoding, default parameters and counter sizing for the start scheduler.
package async_sched_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_e;

    localparam int N_REQ_DEF      = 4;
    localparam int START_LEN_DEF  = 1;
    localparam int TIMEOUT_DEF    = 16;
    localparam int GAP_CYCLES_DEF = 2;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/start_sync_edge.sv
// start_sync_edge: two-flop synchroniser for an asynchronous request plus a one-cycle rising-edge strobe.
module start_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/async_start_scheduler.sv
// async_start_scheduler: round-robin arbiter sharing one async unit among N_REQ requesters,
// sequencing each grant through start pulse, completion/timeout wait and an idle gap.
module async_start_scheduler
    import async_sched_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int START_LEN  = START_LEN_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_in,
    input  logic                     unit_out,
    output logic                     unit_start,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [N_REQ-1:0]         pending,
    output logic                     done_pulse,
    output logic                     timeout_pulse
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(TIMEOUT, START_LEN, GAP_CYCLES);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    grant_q, grant_d, ptr_q, ptr_d, sel;
    logic [N_REQ-1:0] pend_q, pend_d, rise, clr;
    logic             out_prev_q, out_rise;
    logic             done_q, done_d, to_q, to_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        start_sync_edge u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .async_i(req_in[i]),
            .rise_o (rise[i])
        );
    end

    assign out_rise = unit_out & ~out_prev_q;

    // Scan offsets high to low so the nearest set bit at or after the pointer wins.
    always_comb begin
        sel = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pend_q[(int'(ptr_q) + k) % N_REQ]) sel = IW'((int'(ptr_q) + k) % N_REQ);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        clr     = '0;
        done_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    grant_d  = sel;
                    clr[sel] = 1'b1;
                    ptr_d    = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = (cnt_q == CW'(START_LEN - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(START_LEN - 1)) ? WAIT : START;
            end
            WAIT: begin
                if (out_rise) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(GAP_CYCLES - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            pend_q     <= '0;
            out_prev_q <= 1'b0;
            done_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pend_q     <= pend_d;
            out_prev_q <= unit_out;
            done_q     <= done_d;
            to_q       <= to_d;
        end
    end

    assign unit_start    = (state_q == START);
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_q;
    assign pending       = pend_q;
    assign done_pulse    = done_q;
    assign timeout_pulse = to_q;

endmodule

// File: tb/tb_async_start_scheduler.sv
// tb_async_start_scheduler: directed checks of request latency, round-robin order, timeout,
// done-vs-timeout priority, request merging and asynchronous reset.
module tb_async_start_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       unit_out = 1'b0;
    logic [3:0] req_in = 4'b0;
    logic       unit_start, busy, done_pulse, timeout_pulse;
    logic [1:0] grant_id;
    logic [3:0] pending;
    int         errs = 0;
    int         checks = 0;

    always #50 clk = ~clk;

    async_start_scheduler #(
        .N_REQ     (4),
        .START_LEN (1),
        .TIMEOUT   (16),
        .GAP_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .unit_out     (unit_out),
        .unit_start   (unit_start),
        .grant_id     (grant_id),
        .busy         (busy),
        .pending      (pending),
        .done_pulse   (done_pulse),
        .timeout_pulse(timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m);
        req_in = m;
        #70;
        req_in = 4'b0;
    endtask

    task automatic await_start(input string tag, input int exp_n, input int id);
        int n;
        n = 0;
        while (!unit_start && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 32'(unit_start), 1);
        if (exp_n >= 0) chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_id"}, 32'(grant_id), id);
    endtask

    task automatic finish_grant(input string tag);
        tick();
        unit_out = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(done_pulse), 1);
        chk({tag, "_noto"}, 32'(timeout_pulse), 0);
        unit_out = 1'b0;
    endtask

    task automatic serve(input string tag, input int exp_n, input int id);
        await_start(tag, exp_n, id);
        finish_grant(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        tick();
        chk("rst_start", 32'(unit_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_pulses", 32'({done_pulse, timeout_pulse}), 0);
        rst_n = 1'b1;
        tick();

        // single request: latency and done
        pulse(4'b0001);
        tick();
        chk("lat_k0", 32'(pending), 0);
        tick();
        chk("lat_k1", 32'(pending), 0);
        tick();
        chk("lat_k2_pend", 32'(pending), 1);
        chk("lat_k2_start", 32'(unit_start), 0);
        tick();
        chk("lat_k3_start", 32'(unit_start), 1);
        chk("lat_k3_gid", 32'(grant_id), 0);
        chk("lat_k3_pend", 32'(pending), 0);
        chk("lat_k3_busy", 32'(busy), 1);
        tick();
        chk("lat_k4_start", 32'(unit_start), 0);
        tick();
        unit_out = 1'b1;
        tick();
        chk("one_done", 32'(done_pulse), 1);
        tick();
        chk("one_done_end", 32'(done_pulse), 0);
        chk("one_gap_busy", 32'(busy), 1);
        tick();
        chk("one_idle", 32'(busy), 0);
        unit_out = 1'b0;

        // burst from a fresh pointer, then a second burst after the wrap
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse(4'b1111);
        tick(2);
        chk("burst_k1", 32'(pending), 0);
        tick();
        chk("burst_k2", 32'(pending), 4'hf);
        tick();
        chk("burst_k3", 32'(pending), 4'he);
        serve("b0", 0, 0);
        serve("b1", 3, 1);
        serve("b2", 3, 2);
        serve("b3", 3, 3);
        tick(2);
        chk("burst_idle", 32'(busy), 0);
        pulse(4'b1001);
        serve("c0", -1, 0);
        serve("c3", 3, 3);

        // timeout then next request
        pulse(4'b0110);
        await_start("t1", -1, 1);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            seen |= done_pulse | timeout_pulse;
        end
        chk("to_early", 32'(seen), 0);
        tick();
        chk("to_pulse", 32'(timeout_pulse), 1);
        chk("to_nodone", 32'(done_pulse), 0);
        serve("t2", 3, 2);

        // unit_out already high at WAIT entry
        unit_out = 1'b1;
        pulse(4'b0001);
        await_start("h0", -1, 0);
        tick(2);
        chk("high_entry", 32'(done_pulse), 0);
        unit_out = 1'b0;
        tick();
        unit_out = 1'b1;
        tick();
        chk("second_rise", 32'(done_pulse), 1);
        unit_out = 1'b0;

        // rise on the last WAIT cycle: done wins
        pulse(4'b1000);
        await_start("e3", -1, 3);
        tick(16);
        unit_out = 1'b1;
        tick();
        chk("edge16_done", 32'(done_pulse), 1);
        chk("edge16_noto", 32'(timeout_pulse), 0);
        tick();
        chk("edge16_noto2", 32'(timeout_pulse), 0);
        unit_out = 1'b0;

        // re-request while pending merges
        pulse(4'b0010);
        await_start("m1", -1, 1);
        pulse(4'b0100);
        tick(2);
        pulse(4'b0100);
        tick();
        chk("merge_pend", 32'(pending), 4'b0100);
        tick(2);
        chk("merge_pend2", 32'(pending), 4'b0100);
        unit_out = 1'b1;
        tick();
        chk("m1_done", 32'(done_pulse), 1);
        unit_out = 1'b0;
        serve("m2", 3, 2);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= unit_start;
        end
        chk("merge_once", 32'(seen), 0);
        chk("merge_empty", 32'(pending), 0);

        // re-request landing on the grant-clear cycle is kept
        pulse(4'b1100);
        await_start("r3", -1, 3);
        finish_grant("r3");
        pulse(4'b0100);
        serve("r2a", 3, 2);
        chk("setwins_pend", 32'(pending), 4'b0100);
        serve("r2b", 3, 2);

        // asynchronous reset mid-WAIT
        pulse(4'b0011);
        await_start("x0", -1, 0);
        tick(2);
        chk("pre_rst_pend", 32'(pending), 4'b0010);
        chk("pre_rst_busy", 32'(busy), 1);
        #10;
        rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(unit_start), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pend", 32'(pending), 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= done_pulse | timeout_pulse | unit_start | busy;
        end
        chk("post_rst_quiet", 32'(seen), 0);
        pulse(4'b0011);
        serve("y0", -1, 0);
        serve("y1", 3, 1);

        tick(3);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
